// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-access stage.
// Holds the bus FSM encoding and the default bus timeout.
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam int unsigned TimeoutDefault = 16;

endpackage

// File: rtl/MEM_WB_Reg.sv
// MEM/WB pipeline register, clocked on the falling edge like the other pipeline registers.
// A high stall loads a bubble instead of the incoming fields.
module MEM_WB_Reg #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              RegWrite,
   input  logic              MemtoReg,
   input  logic [ADDR_W-1:0] ReadData,
   input  logic [ADDR_W-1:0] ALUResult,
   input  logic [4:0]        RegWriteAdd,
   output logic              RegWrite_Out,
   output logic              MemtoReg_Out,
   output logic [ADDR_W-1:0] ReadData_Out,
   output logic [ADDR_W-1:0] ALUResult_Out,
   output logic [4:0]        RegWriteAdd_Out
);

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWrite_Out    <= 1'b0;
         MemtoReg_Out    <= 1'b0;
         ReadData_Out    <= '0;
         ALUResult_Out   <= '0;
         RegWriteAdd_Out <= '0;
      end else if (stall) begin
         RegWrite_Out    <= 1'b0;
         MemtoReg_Out    <= 1'b0;
         ReadData_Out    <= '0;
         ALUResult_Out   <= '0;
         RegWriteAdd_Out <= '0;
      end else begin
         RegWrite_Out    <= RegWrite;
         MemtoReg_Out    <= MemtoReg;
         ReadData_Out    <= ReadData;
         ALUResult_Out   <= ALUResult;
         RegWriteAdd_Out <= RegWriteAdd;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: runs one data-bus transfer per load/store with timeout, stalls the front of
// the pipeline while the transfer is outstanding, and feeds the MEM/WB register.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT = TimeoutDefault,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              MemtoReg,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] address,
   input  logic [ADDR_W-1:0] ALUResult,
   input  logic [ADDR_W-1:0] WriteData,
   input  logic [4:0]        RegWriteAdd,
   output logic              dbus_req,
   output logic              dbus_we,
   output logic [ADDR_W-1:0] dbus_addr,
   output logic [ADDR_W-1:0] dbus_wdata,
   input  logic              dbus_ack,
   input  logic [ADDR_W-1:0] dbus_rdata,
   output logic              stall,
   output logic              RegWrite_Out,
   output logic              MemtoReg_Out,
   output logic [ADDR_W-1:0] ReadData_Out,
   output logic [ADDR_W-1:0] ALUResult_Out,
   output logic [4:0]        RegWriteAdd_Out,
   output logic              misalign_exc,
   output logic              bus_err
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] wdata_q, wdata_d;
   logic [ADDR_W-1:0] rdata_q, rdata_d;
   logic              we_q, we_d;
   logic              bus_err_q, bus_err_d;
   logic              misalign_q, misalign_d;

   logic              access, aligned, start, misaligned, timeout;
   logic [ADDR_W-1:0] wb_rdata;

   assign access     = MemRead | MemWrite;
   assign aligned    = (address[1:0] == 2'b00);
   assign start      = (state_q == StIdle) & access & aligned;
   assign misaligned = (state_q == StIdle) & access & ~aligned;
   assign timeout    = (cnt_q == CntW'(TIMEOUT - 1));

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StBusy;
         StBusy:  if (dbus_ack || timeout) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Transfer datapath: latch the request on entry, capture the response on exit.
   always_comb begin
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      rdata_d    = rdata_q;
      bus_err_d  = 1'b0;
      misalign_d = misaligned;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               cnt_d   = '0;
               addr_d  = address;
               wdata_d = WriteData;
               we_d    = MemWrite;
            end
         end
         StBusy: begin
            // Ack beats a simultaneous timeout.
            if (dbus_ack) begin
               rdata_d = we_q ? '0 : dbus_rdata;
            end else if (timeout) begin
               rdata_d   = '0;
               bus_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         rdata_q    <= '0;
         bus_err_q  <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         rdata_q    <= rdata_d;
         bus_err_q  <= bus_err_d;
         misalign_q <= misalign_d;
      end
   end

   // Reset gates stall directly so it drops without waiting for a clock edge.
   always_comb begin
      dbus_req     = (state_q == StBusy);
      stall        = rst_n & (start | (state_q == StBusy));
      dbus_we      = we_q;
      dbus_addr    = addr_q;
      dbus_wdata   = wdata_q;
      bus_err      = bus_err_q;
      misalign_exc = misalign_q;
      wb_rdata     = (state_q == StDone) ? rdata_q : '0;
   end

   MEM_WB_Reg #(
      .ADDR_W (ADDR_W)
   ) u_mem_wb (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall           (stall),
      .RegWrite        (RegWrite & ~misaligned),
      .MemtoReg        (MemtoReg),
      .ReadData        (wb_rdata),
      .ALUResult       (ALUResult),
      .RegWriteAdd     (RegWriteAdd),
      .RegWrite_Out    (RegWrite_Out),
      .MemtoReg_Out    (MemtoReg_Out),
      .ReadData_Out    (ReadData_Out),
      .ALUResult_Out   (ALUResult_Out),
      .RegWriteAdd_Out (RegWriteAdd_Out)
   );

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: TIMEOUT, 16, bus cycles waited for dbus_ack before abort; ADDR_W, 32, address/data width.
REQ-002 clk  in  1  single clock; all state SHALL update on negedge clk, like the pipeline registers.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 MemRead, MemWrite, MemtoReg, RegWrite  in  1 each  control fields from the EX/MEM register.
REQ-005 address, ALUResult, WriteData  in  32 each  EX/MEM data fields; RegWriteAdd  in  5.
REQ-006 dbus_req, dbus_we  out  1 each  data-bus request and write enable.
REQ-007 dbus_addr, dbus_wdata  out  32 each; dbus_ack  in  1; dbus_rdata  in  32.
REQ-008 stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-009 RegWrite_Out, MemtoReg_Out  out  1 each; ReadData_Out, ALUResult_Out  out  32 each; RegWriteAdd_Out  out  5: the MEM/WB register.
REQ-010 misalign_exc, bus_err  out  1 each  one-cycle exception pulses.

Function
REQ-011 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-012 access = MemRead | MemWrite; aligned = (address[1:0] == 2'b00).
REQ-013 In IDLE, with access & aligned, the unit SHALL latch address/WriteData/MemWrite into dbus_addr/dbus_wdata/dbus_we and enter BUSY.
REQ-014 If MemRead and MemWrite are both high, the access SHALL be a write.
REQ-015 stall SHALL be combinational: high when (IDLE & access & aligned) or BUSY; low in DONE.
REQ-016 dbus_req SHALL be high in exactly the BUSY cycles; dbus_addr/wdata/we SHALL stay stable throughout BUSY.
REQ-017 In BUSY, dbus_ack high SHALL capture dbus_rdata (reads only; writes capture 0) and move the FSM to DONE.
REQ-018 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-019 If the counter reaches TIMEOUT-1 without ack, the FSM SHALL enter DONE, pulse bus_err for one cycle, and force the captured data to 0.
REQ-020 When ack arrives in the same cycle as timeout, ack SHALL win and bus_err SHALL stay low.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE; the EX/MEM register advances at the end of DONE.
REQ-022 A misaligned access in IDLE SHALL issue no bus cycle, raise no stall, pulse misalign_exc for one cycle, and load MEM/WB with RegWrite_Out=0.
REQ-023 When stall is low, MEM/WB SHALL load the EX/MEM fields, with ReadData_Out taking the captured data (DONE) or 0 (no access).
REQ-024 When stall is high, MEM/WB SHALL load a bubble: RegWrite_Out=0, MemtoReg_Out=0, and all other fields 0.
REQ-025 Latency SHALL be: non-memory instruction 1 cycle; aligned access with ack after k BUSY cycles gives k+2 cycles (IDLE+k BUSY+DONE).

Reset
REQ-026 When rst_n is low, the FSM SHALL go to IDLE and the counter to 0.
REQ-027 When rst_n is low, all outputs SHALL be 0, including dbus_req, stall, and both exception pulses.
REQ-028 Reset during BUSY SHALL drop dbus_req immediately (asynchronously) and discard the transfer; a late dbus_ack after reset SHALL be ignored in IDLE.

Structure
REQ-029 The state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the TIMEOUT default SHALL live in the shared pipeline package / defines file.
REQ-030 The MEM/WB register SHALL be one sub-module, MEM_WB_Reg, with bubble insertion selected by stall; the FSM and counter stay in mem_access_unit.

Verification
REQ-031 Non-memory instruction, ALUResult=0x1234, RegWriteAdd=5 -> stall never high; next negedge ALUResult_Out=0x1234, RegWriteAdd_Out=5, RegWrite_Out=1.
REQ-032 Load from address 0x40, ack on the 3rd BUSY cycle with rdata=0xDEADBEEF -> stall high 4 cycles, dbus_req high 3 cycles, then ReadData_Out=0xDEADBEEF, MemtoReg_Out=1.
REQ-033 Store to 0x80 with WriteData=0xA5A5A5A5, ack on the 1st BUSY cycle -> dbus_we=1, dbus_wdata=0xA5A5A5A5, stall high 2 cycles, RegWrite_Out=0.
REQ-034 Load from 0x41 -> no dbus_req, misalign_exc high one cycle, stall low, RegWrite_Out=0.
REQ-035 Load with no ack and TIMEOUT=16 -> dbus_req high 16 cycles, bus_err pulses, ReadData_Out=0, FSM back to IDLE.
REQ-036 rst_n asserted in the 2nd BUSY cycle -> dbus_req and stall drop at once; an ack after reset release causes no state change.
